// File: rtl/stereo_pkg.sv
// Shared types and sizing for the stereo SAD disparity search.
// Block is 6 rows of 48 bits, with six 8-bit pixels per row.
package stereo_pkg;
    localparam int BLOCK_SIZE = 6;
    localparam int PIX_W      = 8;
    localparam int WORD_W     = 48;
    localparam int SAD_W      = 14;
    localparam int ROW_SAD_W  = 11;
    localparam int MAX_DISP   = 40;
    localparam int DISP_W     = $clog2(MAX_DISP);

    typedef logic [BLOCK_SIZE-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2
    } sad_state_t;
endpackage

// File: rtl/sad_row_unit.sv
// Combinational row SAD: six absolute pixel differences summed to 11 bits.
// Each difference is formed in 9 bits and truncated to 8 bits before summing.
module sad_row_unit
    import stereo_pkg::*;
(
    input  logic [WORD_W-1:0]    row_a_i,
    input  logic [WORD_W-1:0]    row_b_i,
    output logic [ROW_SAD_W-1:0] sad_o
);
    logic [PIX_W:0]   diff;
    logic [PIX_W-1:0] abs_diff;

    always_comb begin
        sad_o    = '0;
        diff     = '0;
        abs_diff = '0;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            diff     = {1'b0, row_a_i[k*PIX_W +: PIX_W]} - {1'b0, row_b_i[k*PIX_W +: PIX_W]};
            abs_diff = diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];
            sad_o    = sad_o + {3'b000, abs_diff};
        end
    end
endmodule

// File: rtl/sad_disparity_search.sv
// Scores a sequence of right candidate blocks against one left block by SAD, one row per cycle,
// and reports the index of the minimum-SAD candidate (earliest wins on ties) when the search ends.
module sad_disparity_search
    import stereo_pkg::*;
(
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          valid_in,
    input  logic                          first_in,
    input  logic                          last_in,
    input  logic [5:0][47:0]              left_block,
    input  logic [5:0][47:0]              right_block,
    output logic                          ready_out,
    output logic                          valid_out,
    output logic [DISP_W-1:0]             disparity_out,
    output logic [SAD_W-1:0]              sad_out,
    output logic                          drop_err_out
);
    localparam logic [2:0]        ROW_LAST = 3'(BLOCK_SIZE - 1);
    localparam logic [DISP_W-1:0] CAND_CAP = DISP_W'(MAX_DISP - 1);

    sad_state_t        state_q, state_d;
    block_t            left_q, right_q;
    logic              last_q;
    logic              open_q;
    logic [2:0]        row_q;
    logic [SAD_W-1:0]  acc_q;
    logic [DISP_W-1:0] cand_idx_q;
    logic [SAD_W-1:0]  best_sad_q;
    logic [DISP_W-1:0] best_idx_q;
    logic              valid_q;
    logic [DISP_W-1:0] disp_q;
    logic [SAD_W-1:0]  sad_q;
    logic              drop_q;

    logic [ROW_SAD_W-1:0] row_sad;
    logic                 better;
    logic                 final_cand;
    logic [SAD_W-1:0]     best_sad_d;
    logic [DISP_W-1:0]    best_idx_d;

    sad_row_unit u_row (
        .row_a_i (left_q[row_q]),
        .row_b_i (right_q[row_q]),
        .sad_o   (row_sad)
    );

    // Strict compare so an equal SAD keeps the earlier candidate.
    assign better     = acc_q < best_sad_q;
    assign best_sad_d = better ? acc_q : best_sad_q;
    assign best_idx_d = better ? cand_idx_q : best_idx_q;
    assign final_cand = last_q || (cand_idx_q == CAND_CAP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in) state_d = ACCUM;
            ACCUM:   if (row_q == ROW_LAST) state_d = COMPARE;
            COMPARE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            left_q     <= '0;
            right_q    <= '0;
            last_q     <= 1'b0;
            open_q     <= 1'b0;
            row_q      <= '0;
            acc_q      <= '0;
            cand_idx_q <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
            valid_q    <= 1'b0;
            disp_q     <= '0;
            sad_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            if (valid_in && state_q != IDLE) drop_q <= 1'b1;
            case (state_q)
                IDLE: if (valid_in) begin
                    left_q  <= left_block;
                    right_q <= right_block;
                    last_q  <= last_in;
                    acc_q   <= '0;
                    row_q   <= '0;
                    open_q  <= 1'b1;
                    // A stray non-first candidate with no search open starts a fresh search.
                    if (first_in || !open_q) begin
                        cand_idx_q <= '0;
                        best_sad_q <= '1;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + {3'b000, row_sad};
                    row_q <= row_q + 3'd1;
                end
                COMPARE: begin
                    best_sad_q <= best_sad_d;
                    best_idx_q <= best_idx_d;
                    if (final_cand) begin
                        disp_q  <= best_idx_d;
                        sad_q   <= best_sad_d;
                        valid_q <= 1'b1;
                        open_q  <= 1'b0;
                    end else begin
                        cand_idx_q <= cand_idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_out     = (state_q == IDLE);
    assign valid_out     = valid_q;
    assign disparity_out = disp_q;
    assign sad_out       = sad_q;
    assign drop_err_out  = drop_q;
endmodule
